// File: rtl/p2s_frame_controller.sv
// rtl/p2s_frame_controller.sv - load/send/gap sequencer for a parallel-to-serial converter
//
// Ports:
//   clock      - system clock, rising edge
//   reset      - asynchronous active-low reset
//   enable     - gates acceptance of new words; an in-flight frame always completes
//   in_valid   - upstream word valid
//   in_data    - upstream parallel word
//   in_ready   - registered: controller can accept a word this cycle
//   par_data   - word held stable for the converter from handshake to next handshake
//   load_send  - converter control: 0 = load/hold, 1 = shift
//   bit_index  - index of the bit being shifted, 0 outside SEND
//   busy       - high in LOAD, SEND and GAP
//   frame_done - one-cycle pulse after the last shift cycle
module p2s_frame_controller #(
    parameter int WIDTH       = 8,
    parameter int LOAD_CYCLES = 1,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] par_data,
    output logic             load_send,
    output logic [CNT_W-1:0] bit_index,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    // Counters are preloaded with (cycles - 1) and count down to zero.
    localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_INIT  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(WIDTH - 1);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic [CNT_W-1:0] bit_index_d;
    logic [WIDTH-1:0] par_data_d;
    logic             in_ready_d, load_send_d, busy_d, frame_done_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            in_ready   <= 1'b0;
            par_data   <= '0;
            load_send  <= 1'b0;
            bit_index  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            in_ready   <= in_ready_d;
            par_data   <= par_data_d;
            load_send  <= load_send_d;
            bit_index  <= bit_index_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        in_ready_d   = in_ready;
        par_data_d   = par_data;
        load_send_d  = load_send;
        bit_index_d  = bit_index;
        busy_d       = busy;
        frame_done_d = 1'b0;

        case (state)
            IDLE: begin
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
                load_send_d = 1'b0;
                bit_index_d = '0;
                cnt_d       = '0;
                // The handshake uses the registered in_ready, so the first
                // edge after reset release can never accept a word.
                if (in_valid && in_ready && enable) begin
                    par_data_d = in_data;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    cnt_d      = LOAD_INIT;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                load_send_d = 1'b0;
                if (cnt == '0) begin
                    load_send_d = 1'b1;
                    bit_index_d = '0;
                    state_d     = SEND;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            SEND: begin
                // bit_index doubles as the send-cycle counter.
                if (bit_index == LAST_BIT) begin
                    load_send_d  = 1'b0;
                    bit_index_d  = '0;
                    frame_done_d = 1'b1;
                    if (GAP_CYCLES == 0) begin
                        in_ready_d = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        cnt_d   = GAP_INIT;
                        state_d = GAP;
                    end
                end else begin
                    bit_index_d = bit_index + 1'b1;
                end
            end
            GAP: begin
                load_send_d = 1'b0;
                if (cnt == '0) begin
                    in_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cnt_d       = '0;
                in_ready_d  = 1'b1;
                par_data_d  = '0;
                load_send_d = 1'b0;
                bit_index_d = '0;
                busy_d      = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_p2s_frame_controller.sv
// tb/tb_p2s_frame_controller.sv - self-checking bench for p2s_frame_controller
module tb_p2s_frame_controller;

    localparam int L = 1;
    localparam int W = 8;
    localparam int G = 2;

    logic       clock;
    logic       reset;
    logic       enable;
    logic       in_valid, in_valid_b;
    logic [7:0] in_data, in_data_b;
    logic       in_ready, in_ready_b;
    logic [7:0] par_data, par_data_b;
    logic       load_send, load_send_b;
    logic [3:0] bit_index, bit_index_b;
    logic       busy, busy_b;
    logic       frame_done, frame_done_b;

    int vectors = 0;
    int miscompares = 0;
    int fd_count_b = 0;
    logic [7:0] q[$];
    logic [7:0] qb[$];

    p2s_frame_controller #(.WIDTH(W), .LOAD_CYCLES(L), .GAP_CYCLES(G), .CNT_W(4)) dut (
        .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .par_data(par_data),
        .load_send(load_send), .bit_index(bit_index), .busy(busy),
        .frame_done(frame_done)
    );

    p2s_frame_controller #(.WIDTH(8), .LOAD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(4)) dut_b (
        .clock(clock), .reset(reset), .enable(enable), .in_valid(in_valid_b),
        .in_data(in_data_b), .in_ready(in_ready_b), .par_data(par_data_b),
        .load_send(load_send_b), .bit_index(bit_index_b), .busy(busy_b),
        .frame_done(frame_done_b)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting for DUT at %0t", name, $time);
    endtask

    // Scoreboards: push on predicted handshake, pop on frame_done.
    always @(negedge clock) begin
        if (!reset) begin
            q.delete();
            qb.delete();
        end else begin
            if (frame_done) begin
                if (q.size() == 0) timeout("spurious_frame_done");
                else check("sb_par_data", {8'h00, par_data}, {8'h00, q.pop_front()});
            end
            if (in_valid && in_ready && enable) q.push_back(in_data);
            if (frame_done_b) begin
                fd_count_b++;
                if (qb.size() == 0) timeout("spurious_frame_done_b");
                else check("sb_par_data_b", {8'h00, par_data_b}, {8'h00, qb.pop_front()});
            end
            if (in_valid_b && in_ready_b && enable) qb.push_back(in_data_b);
        end
    end

    // Expected {in_ready, load_send, bit_index, busy, frame_done} k edges after t0.
    function automatic logic [7:0] exp_ctl(input int k);
        if (k < L)              return {1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
        else if (k < L + W)     return {1'b0, 1'b1, 4'(k - L), 1'b1, 1'b0};
        else if (k == L + W)    return {1'b0, 1'b0, 4'd0, 1'b1, 1'b1};
        else if (k < L + W + G) return {1'b0, 1'b0, 4'd0, 1'b1, 1'b0};
        else                    return {1'b1, 1'b0, 4'd0, 1'b0, 1'b0};
    endfunction

    task automatic wait_hs(output int waited, output bit found);
        found = 0;
        waited = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            waited++;
            if (in_ready && enable) found = 1;
        end
    endtask

    task automatic run_frame(input logic [7:0] word, input logic [7:0] exp_par,
                             input bit toggle, input bit drop_en, output int waited);
        bit found;
        in_valid = 1'b1;
        in_data  = word;
        wait_hs(waited, found);
        if (!found) begin
            timeout("handshake");
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        in_valid = toggle;
        for (int k = 0; k <= L + W + G; k++) begin
            if (k > 0) begin
                @(posedge clock);
                #1;
            end
            check($sformatf("frame_k%0d", k),
                  {exp_ctl(k), exp_par},
                  {in_ready, load_send, bit_index, busy, frame_done, par_data});
            if (toggle) in_data = 8'($urandom);
            if (drop_en && k == 3) enable = 1'b0;
        end
        if (drop_en) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clock);
                check("no_accept_disabled", {13'h0, in_ready, busy, load_send}, {13'h0, 3'b100});
            end
            in_valid = 1'b0;
            enable = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         toggle;
        bit         drop_en;
        logic [7:0] exp_par;
    } vec_t;

    initial begin
        vec_t tbl[4];
        int   waited;
        bit   found;
        int   edges;
        bit   hs;
        logic hist [0:31];

        tbl[0] = '{8'hA5, 1'b0, 1'b0, 8'hA5};
        tbl[1] = '{8'hFF, 1'b0, 1'b0, 8'hFF};
        tbl[2] = '{8'h00, 1'b0, 1'b0, 8'h00};
        tbl[3] = '{8'h5A, 1'b1, 1'b1, 8'h5A};

        reset = 1'b1; enable = 1'b1;
        in_valid = 1'b0; in_data = 8'h00;
        in_valid_b = 1'b0; in_data_b = 8'h00;
        #1 reset = 1'b0;

        // Reset release
        repeat (3) begin
            @(negedge clock);
            check("in_reset", {in_ready, load_send, bit_index, busy, frame_done, par_data}, 16'h0000);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_release", {14'h0, in_ready, load_send}, {14'h0, 2'b10});

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            run_frame(tbl[i].data, tbl[i].exp_par, tbl[i].toggle, tbl[i].drop_en, waited);
        end

        // enable=0 blocks handshake; raising enable accepts on the next edge
        enable = 1'b0;
        in_valid = 1'b1;
        in_data = 8'h3C;
        repeat (10) begin
            @(negedge clock);
            check("enable_low_blocks", {13'h0, in_ready, busy, load_send}, {13'h0, 3'b100});
        end
        @(posedge clock);
        #1;
        enable = 1'b1;
        run_frame(8'h3C, 8'h3C, 1'b0, 1'b0, waited);
        check("enable_rise_latency", 16'(waited), 16'd1);

        // Reset asserted mid-SEND
        in_valid = 1'b1;
        in_data = 8'hC3;
        wait_hs(waited, found);
        if (!found) timeout("hs_reset_test");
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("pre_reset_sending", {14'h0, load_send, busy}, {14'h0, 2'b11});
        reset = 1'b0;
        #1;
        check("async_reset", {in_ready, load_send, bit_index, busy, frame_done, par_data}, 16'h0000);
        repeat (3) begin
            @(negedge clock);
            check("no_done_in_reset", {15'h0, frame_done}, 16'h0000);
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("ready_after_mid_reset", {15'h0, in_ready}, 16'h0001);
        run_frame(8'h96, 8'h96, 1'b0, 1'b0, waited);

        // Back-to-back on the zero-gap instance
        in_valid_b = 1'b1;
        in_data_b = 8'h01;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clock);
            if (in_ready_b) found = 1;
        end
        if (!found) timeout("hs_b2b_first");
        @(posedge clock);
        #1;
        in_data_b = 8'h80;
        edges = 0;
        hs = 0;
        for (int i = 0; i < 30 && !hs; i++) begin
            @(negedge clock);
            hs = in_ready_b;
            @(posedge clock);
            edges++;
            #1;
            if (!hs) hist[edges] = load_send_b;
        end
        if (!hs) timeout("hs_b2b_second");
        in_valid_b = 1'b0;
        check("b2b_period", 16'(edges), 16'd10);
        check("b2b_last_send", {15'h0, hist[8]}, 16'h0001);
        check("b2b_done_cycle", {15'h0, hist[9]}, 16'h0000);
        check("b2b_load_cycle", {15'h0, load_send_b}, 16'h0000);
        @(posedge clock);
        #1;
        check("b2b_second_send", {15'h0, load_send_b}, 16'h0001);
        repeat (12) @(posedge clock);
        #1;
        check("b2b_done_count", 16'(fd_count_b), 16'd2);
        check("b2b_idle", {14'h0, in_ready_b, busy_b}, {14'h0, 2'b10});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/p2s_frame_controller.md
Name: p2s_frame_controller

Overview:
Sequencing controller for the parallel-to-serial converter. It accepts parallel words from an upstream producer through a valid/ready handshake and presents each word on par_data. It drives the converter's load_send control through the phases load, send (WIDTH shift cycles) and inter-frame gap, and reports frame completion. It sits directly between the word source and the converter and is the sole owner of load_send.

Parameters:
WIDTH, 8, word width and number of send cycles per frame (>=2)
LOAD_CYCLES, 1, cycles load_send is held low in LOAD before sending (>=1)
GAP_CYCLES, 2, idle cycles after each frame before the next word is accepted (>=0)
CNT_W, 4, width of bit_index and internal counters (must hold max(WIDTH, LOAD_CYCLES, GAP_CYCLES))

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
enable  input  1  1 = new frames may be accepted; 0 = block acceptance only
in_valid  input  1  upstream word valid
in_data  input  WIDTH  upstream parallel word
in_ready  output  1  controller can accept a word (registered)
par_data  output  WIDTH  word held stable for the converter for the whole frame
load_send  output  1  converter control: 0 = load/hold, 1 = send (shift)
bit_index  output  CNT_W  index of the bit being sent (0..WIDTH-1); 0 outside SEND
busy  output  1  1 in LOAD, SEND and GAP
frame_done  output  1  one-cycle pulse when the last send cycle completes

Behaviour:
- All outputs are registered. Reset is asynchronous, active-low, and applies immediately:
  - state=IDLE;
  - in_ready=0, load_send=0, par_data=0, bit_index=0, busy=0, frame_done=0;
  - all counters=0.
- First rising edge after reset deasserts: in_ready becomes 1.
- States: IDLE, LOAD, SEND, GAP.
- IDLE:
  - in_ready=1, busy=0, load_send=0.
  - Handshake occurs at edge t0 where in_valid && in_ready && enable.
  - At t0: par_data<=in_data, in_ready<=0, busy<=1, state<=LOAD.
  - If enable=0, in_valid is ignored. in_ready stays 1; the handshake is qualified by enable.
- LOAD:
  - load_send=0 for LOAD_CYCLES cycles.
  - At edge t0+LOAD_CYCLES: load_send<=1, bit_index<=0, state<=SEND.
- SEND:
  - load_send=1 for exactly WIDTH cycles; bit_index increments each edge.
  - At edge t0+LOAD_CYCLES+WIDTH: load_send<=0, bit_index<=0, frame_done<=1 for one cycle.
  - Next state is GAP; if GAP_CYCLES=0, go straight to IDLE with in_ready<=1 and busy<=0.
- GAP:
  - load_send=0, busy=1 for GAP_CYCLES cycles.
  - At edge t0+LOAD_CYCLES+WIDTH+GAP_CYCLES: in_ready<=1, busy<=0, state<=IDLE.
- par_data is stable from t0 until the next handshake. It is never modified mid-frame, and changes on in_data are ignored while busy.
- enable dropping mid-frame does not stop the frame. The frame completes, including GAP, and the controller then waits in IDLE.
- Back-to-back operation: minimum frame period is 1 (handshake) + LOAD_CYCLES + WIDTH + GAP_CYCLES edges between successive handshakes. With in_valid held high, the next handshake lands on the edge after in_ready rises.
- Reset asserted mid-frame: everything returns to reset values immediately. The in-flight word is dropped with no frame_done, and upstream must re-present it.
- Illegal or unreachable state encodings: return to IDLE on the next edge with reset output values, except in_ready<=1.

Test Plan:
- Reset release: hold reset=0 for 3 cycles, then 1 -> all outputs 0 during reset; in_ready=1 one edge after release; load_send stays 0.
- Single frame, defaults, in_data=8'hA5 accepted at t0 -> par_data=8'hA5 from t0; load_send=0 at t0, 1 from t0+1 through t0+8, 0 at t0+9; bit_index 0..7; frame_done=1 only in cycle t0+9; in_ready=1 at t0+11.
- enable=0 with in_valid=1 for 10 cycles -> no handshake, busy=0, load_send=0. Raise enable -> handshake on the next edge.
- Back-to-back with GAP_CYCLES=0, in_valid held, words 8'h01 then 8'h80 -> second handshake exactly 10 edges after the first; load_send low for exactly 2 cycles between the two send bursts; two frame_done pulses.
- Reset asserted at t0+5, mid-SEND -> load_send, busy and par_data go to 0 without waiting for a clock edge; no frame_done; after release a new word is accepted normally.
- in_data toggled every cycle during SEND and enable dropped at t0+3 -> par_data unchanged; frame completes with frame_done at t0+9; no new acceptance while enable=0.
